// File: rtl/qbus_initiator.sv
// QBUS DATI/DATO(B) bus-cycle initiator with a 2-flop RRPLY synchronizer and registered bus strobes.
// Optional reply timeout (NXM) is built only when QBUS_INITIATOR_TIMEOUT_EN is defined.
module qbus_initiator #(
  parameter int ADDR_SETUP = 3,
  parameter int ADDR_HOLD  = 2,
  parameter int TIMEOUT    = 200
) (
  input  logic        clk20,
  input  logic        reset,
  input  logic        start,
  input  logic        bus_master,
  input  logic        write,
  input  logic        byte_wr,
  input  logic [21:0] addr,
  input  logic        bs7,
  input  logic [15:0] wdata,
  input  logic        RRPLY,
  input  logic [15:0] RDL,
  output logic        TSYNC,
  output logic        TDIN,
  output logic        TDOUT,
  output logic        TWTBT,
  output logic        TBS7,
  output logic [21:0] TDAL,
  output logic        dal_tx,
  output logic        busy,
  output logic        done,
  output logic        nxm,
  output logic [15:0] rdata
);
  localparam int PMAX = (ADDR_SETUP > ADDR_HOLD) ? ADDR_SETUP : ADDR_HOLD;
  localparam int PW   = $clog2(PMAX + 1);
  localparam logic [PW-1:0] SETUP_LAST = PW'(ADDR_SETUP - 1);
  localparam logic [PW-1:0] HOLD_LAST  = PW'(ADDR_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_SYNC, S_DATA, S_WAIT, S_LATCH, S_END, S_RELEASE
  } state_t;

  state_t state_q, state_d;
  logic [PW-1:0] ph_cnt_q, ph_cnt_d;
  logic        wr_q, wr_d, byte_q, byte_d;
  logic [15:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic        tsync_q, tsync_d, tdin_q, tdin_d, tdout_q, tdout_d;
  logic        twtbt_q, twtbt_d, tbs7_q, tbs7_d, dal_tx_q, dal_tx_d;
  logic [21:0] tdal_q, tdal_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic        rrply_s1_q, rrply_s2_q;
`ifdef QBUS_INITIATOR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          nxm_q, nxm_d;
`endif

  always_ff @(posedge clk20 or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start && bus_master) state_d = S_ADDR;
      S_ADDR:    if (ph_cnt_q == SETUP_LAST) state_d = S_SYNC;
      S_SYNC:    if (ph_cnt_q == HOLD_LAST) state_d = S_DATA;
      S_DATA:    state_d = S_WAIT;
      S_WAIT: begin
        if (rrply_s2_q) state_d = S_LATCH;
`ifdef QBUS_INITIATOR_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) state_d = S_END;
`endif
      end
      S_LATCH:   state_d = S_END;
      S_END:     if (!rrply_s2_q) state_d = S_RELEASE;
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ph_cnt_d = '0;
    wr_d     = wr_q;
    byte_d   = byte_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    tsync_d  = tsync_q;
    tdin_d   = tdin_q;
    tdout_d  = tdout_q;
    twtbt_d  = twtbt_q;
    tbs7_d   = tbs7_q;
    dal_tx_d = dal_tx_q;
    tdal_d   = tdal_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef QBUS_INITIATOR_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
    nxm_d    = nxm_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && bus_master) begin
          wr_d     = write;
          byte_d   = byte_wr;
          wdata_d  = wdata;
          busy_d   = 1'b1;
          dal_tx_d = 1'b1;
          tdal_d   = addr;
          tbs7_d   = bs7;
          twtbt_d  = write;
`ifdef QBUS_INITIATOR_TIMEOUT_EN
          nxm_d    = 1'b0;
`endif
        end
      end
      S_ADDR: begin
        if (ph_cnt_q == SETUP_LAST) tsync_d = 1'b1;
        else                        ph_cnt_d = ph_cnt_q + 1'b1;
      end
      S_SYNC: begin
        if (ph_cnt_q == HOLD_LAST) begin
          tbs7_d = 1'b0;
          if (wr_q) begin
            tdal_d   = {6'b0, wdata_q};
            twtbt_d  = byte_q;
            dal_tx_d = 1'b1;
          end else begin
            // Release the lines before asserting TDIN so the slave can drive data.
            tdal_d   = '0;
            twtbt_d  = 1'b0;
            dal_tx_d = 1'b0;
            tdin_d   = 1'b1;
          end
        end else begin
          ph_cnt_d = ph_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (wr_q) tdout_d = 1'b1;
`ifdef QBUS_INITIATOR_TIMEOUT_EN
        to_cnt_d = '0;
`endif
      end
      S_WAIT: begin
`ifdef QBUS_INITIATOR_TIMEOUT_EN
        if (!rrply_s2_q) begin
          if (to_cnt_q == TO_LAST) begin
            nxm_d   = 1'b1;
            tdin_d  = 1'b0;
            tdout_d = 1'b0;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
`endif
      end
      S_LATCH: begin
        if (!wr_q) rdata_d = RDL;
        tdin_d  = 1'b0;
        tdout_d = 1'b0;
      end
      S_END: begin
        if (!rrply_s2_q) begin
          tsync_d  = 1'b0;
          dal_tx_d = 1'b0;
          twtbt_d  = 1'b0;
          tdal_d   = '0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk20 or posedge reset) begin
    if (reset) begin
      ph_cnt_q   <= '0;
      wr_q       <= 1'b0;
      byte_q     <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      tsync_q    <= 1'b0;
      tdin_q     <= 1'b0;
      tdout_q    <= 1'b0;
      twtbt_q    <= 1'b0;
      tbs7_q     <= 1'b0;
      dal_tx_q   <= 1'b0;
      tdal_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rrply_s1_q <= 1'b0;
      rrply_s2_q <= 1'b0;
`ifdef QBUS_INITIATOR_TIMEOUT_EN
      to_cnt_q   <= '0;
      nxm_q      <= 1'b0;
`endif
    end else begin
      ph_cnt_q   <= ph_cnt_d;
      wr_q       <= wr_d;
      byte_q     <= byte_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      tsync_q    <= tsync_d;
      tdin_q     <= tdin_d;
      tdout_q    <= tdout_d;
      twtbt_q    <= twtbt_d;
      tbs7_q     <= tbs7_d;
      dal_tx_q   <= dal_tx_d;
      tdal_q     <= tdal_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rrply_s1_q <= RRPLY;
      rrply_s2_q <= rrply_s1_q;
`ifdef QBUS_INITIATOR_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
      nxm_q      <= nxm_d;
`endif
    end
  end

  assign TSYNC  = tsync_q;
  assign TDIN   = tdin_q;
  assign TDOUT  = tdout_q;
  assign TWTBT  = twtbt_q;
  assign TBS7   = tbs7_q;
  assign TDAL   = tdal_q;
  assign dal_tx = dal_tx_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign rdata  = rdata_q;
`ifdef QBUS_INITIATOR_TIMEOUT_EN
  assign nxm    = nxm_q;
`else
  assign nxm    = 1'b0;
`endif
endmodule

// File: tb/tb_qbus_initiator.sv
// Bench for qbus_initiator: table of bus cycles against a cycle-level responder, plus
// hand-written sequences for ignored starts, timeout (when enabled) and reset in WAIT.
module tb_qbus_initiator;
  localparam int ADDR_SETUP = 3;
  localparam int ADDR_HOLD  = 2;
  localparam int TIMEOUT    = 200;
  localparam int LIMIT      = 400;

  logic        clk20 = 1'b0, reset = 1'b1;
  logic        start = 1'b0, bus_master = 1'b1, write = 1'b0, byte_wr = 1'b0, bs7 = 1'b0;
  logic [21:0] addr = '0;
  logic [15:0] wdata = '0, RDL = '0;
  logic        RRPLY = 1'b0;
  logic        TSYNC, TDIN, TDOUT, TWTBT, TBS7, dal_tx, busy, done, nxm;
  logic [21:0] TDAL;
  logic [15:0] rdata;

  qbus_initiator #(.ADDR_SETUP(ADDR_SETUP), .ADDR_HOLD(ADDR_HOLD), .TIMEOUT(TIMEOUT)) dut (
    .clk20(clk20), .reset(reset), .start(start), .bus_master(bus_master), .write(write),
    .byte_wr(byte_wr), .addr(addr), .bs7(bs7), .wdata(wdata), .RRPLY(RRPLY), .RDL(RDL),
    .TSYNC(TSYNC), .TDIN(TDIN), .TDOUT(TDOUT), .TWTBT(TWTBT), .TBS7(TBS7), .TDAL(TDAL),
    .dal_tx(dal_tx), .busy(busy), .done(done), .nxm(nxm), .rdata(rdata)
  );

  always #25 clk20 = ~clk20;

  typedef struct {
    logic        write;
    logic        byte_wr;
    logic [21:0] addr;
    logic        bs7;
    logic [15:0] wdata;
    logic [15:0] rdl;
    int          dly;
    logic        poke;
    logic        drop_bm;
    logic [15:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic [15:0] rdata;
    logic        nxm;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_done();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", sb_q.size(), 1);
    end else begin
      e = sb_q.pop_front();
      chk("done_rdata", rdata, e.rdata);
      chk("done_nxm", nxm, e.nxm);
    end
    chk("done_busy", busy, 0);
    chk("done_tsync", TSYNC, 0);
    chk("done_dal_tx", dal_tx, 0);
  endtask

  // Drive one bus cycle; the loop also acts as the slave, replying v.dly cycles after the strobe.
  task automatic run_txn(input vec_t v);
    int  seen;
    int  overlap;
    bit  fin;
    @(negedge clk20);
    start = 1'b1; write = v.write; byte_wr = v.byte_wr; addr = v.addr;
    bs7 = v.bs7; wdata = v.wdata; bus_master = 1'b1;
    sb_q.push_back('{rdata: v.exp_rdata, nxm: 1'b0});
    seen = -1; overlap = 0; fin = 1'b0;
    for (int k = 1; k <= LIMIT && !fin; k++) begin
      @(negedge clk20);
      start = 1'b0;
      if (v.poke && (k == 3 || k == 9)) begin
        start = 1'b1; addr = ~v.addr; write = ~v.write; bs7 = ~v.bs7;
      end
      if (v.drop_bm && k == 2) bus_master = 1'b0;
      if (k == 1) begin
        chk("a_dal_tx", dal_tx, 1);
        chk("a_tdal", TDAL, v.addr);
        chk("a_tbs7", TBS7, v.bs7);
        chk("a_twtbt", TWTBT, v.write);
        chk("a_busy", busy, 1);
        chk("a_nxm_clr", nxm, 0);
      end
      if (k == ADDR_SETUP) chk("setup_tsync_lo", TSYNC, 0);
      if (k == ADDR_SETUP + 1) chk("tsync_hi", TSYNC, 1);
      if (k == ADDR_SETUP + ADDR_HOLD) begin
        chk("hold_tdal", TDAL, v.addr);
        chk("hold_tbs7", TBS7, v.bs7);
      end
      if (k == ADDR_SETUP + ADDR_HOLD + 1) begin
        chk("d_tdal", TDAL, v.write ? {6'b0, v.wdata} : 22'h0);
        chk("d_dal_tx", dal_tx, v.write);
        chk("d_tbs7", TBS7, 0);
        chk("d_twtbt", TWTBT, v.write & v.byte_wr);
        chk("d_tdin", TDIN, !v.write);
        chk("d_tdout", TDOUT, 0);
      end
      if (k == ADDR_SETUP + ADDR_HOLD + 2) begin
        chk("d2_tdout", TDOUT, v.write);
        chk("d2_tdin", TDIN, !v.write);
      end
      if (TDIN && TDOUT) overlap++;
      if (done) begin
        chk_done();
        chk("done_after_rrply_neg", RRPLY, 0);
        fin = 1'b1;
      end
      if ((TDIN || TDOUT) && seen < 0) seen = 0;
      if (seen >= 0 && (TDIN || TDOUT) && !RRPLY) begin
        if (seen >= v.dly) begin RRPLY = 1'b1; RDL = v.rdl; end
        seen++;
      end
      if (!(TDIN || TDOUT) && RRPLY) begin RRPLY = 1'b0; RDL = 16'hDEAD; end
    end
    chk("done_seen", fin, 1);
    chk("tdin_tdout_overlap", overlap, 0);
    @(negedge clk20);
    chk("done_one_cycle", done, 0);
    bus_master = 1'b1;
  endtask

  initial begin
    vec_t tbl[6];
    vec_t v;
    logic [5:0] act;
    bit fin, saw;
    int t_din;

    tbl[0] = '{1'b0, 1'b0, 22'o17777546, 1'b1, 16'h0000, 16'o000200, 6, 1'b0, 1'b0, 16'o000200};
    tbl[1] = '{1'b1, 1'b0, 22'o1000,     1'b0, 16'o123456, 16'h0000, 3, 1'b1, 1'b0, 16'o000200};
    tbl[2] = '{1'b1, 1'b1, 22'o1001,     1'b0, 16'o000377, 16'h0000, 1, 1'b0, 1'b0, 16'o000200};
    tbl[3] = '{1'b0, 1'b0, 22'h3FFFFF,   1'b0, 16'h1234, 16'hFFFF,   0, 1'b0, 1'b1, 16'hFFFF};
    tbl[4] = '{1'b0, 1'b0, 22'h000000,   1'b1, 16'h0000, 16'h5A5A,  10, 1'b1, 1'b0, 16'h5A5A};
    tbl[5] = '{1'b1, 1'b0, 22'h2AAAAA,   1'b1, 16'h0000, 16'h0000,   2, 1'b0, 1'b0, 16'h5A5A};

    #1;
    chk("rst_flags", {TSYNC, TDIN, TDOUT, TWTBT, TBS7, dal_tx, busy, done, nxm}, 0);
    chk("rst_tdal", TDAL, 0);
    chk("rst_rdata", rdata, 0);
    repeat (2) @(negedge clk20);
    reset = 1'b0;

    foreach (tbl[i]) run_txn(tbl[i]);

    // Idle start without mastership must leave the bus untouched.
    @(negedge clk20);
    bus_master = 1'b0; start = 1'b1; write = 1'b1; addr = 22'o7777;
    @(negedge clk20);
    start = 1'b0; act = '0;
    repeat (20) begin
      @(negedge clk20);
      act |= {busy, dal_tx, TSYNC, TDIN, TDOUT, done};
    end
    chk("bm0_activity", act, 0);
    chk("bm0_tdal", TDAL, 0);
    chk("bm0_rdata", rdata, 16'h5A5A);
    bus_master = 1'b1;

`ifdef QBUS_INITIATOR_TIMEOUT_EN
    @(negedge clk20);
    start = 1'b1; write = 1'b0; addr = 22'o777; bs7 = 1'b0;
    sb_q.push_back('{rdata: 16'h5A5A, nxm: 1'b1});
    t_din = -1; fin = 1'b0;
    for (int c = 1; c <= TIMEOUT + 100 && !fin; c++) begin
      @(negedge clk20);
      start = 1'b0;
      if (TDIN && t_din < 0) t_din = c;
      if (done) begin
        chk("to_latency", (c - t_din >= TIMEOUT) && (c - t_din <= TIMEOUT + 3), 1);
        chk_done();
        chk("to_tdin", TDIN, 0);
        fin = 1'b1;
      end
    end
    chk("to_done_seen", fin, 1);
    repeat (3) @(negedge clk20);
    chk("to_nxm_hold", nxm, 1);
`endif

    // Reset asserted while a DATI waits for a reply that never comes.
    @(negedge clk20);
    start = 1'b1; write = 1'b0; addr = 22'o1234; bs7 = 1'b1;
    @(negedge clk20);
    start = 1'b0;
`ifdef QBUS_INITIATOR_TIMEOUT_EN
    repeat (30) @(negedge clk20);
`else
    repeat (300) @(negedge clk20);
    chk("wait_nxm", nxm, 0);
`endif
    chk("wait_busy", busy, 1);
    chk("wait_tdin", TDIN, 1);
    #5 reset = 1'b1;
    #1;
    chk("arst_flags", {TSYNC, TDIN, TDOUT, TWTBT, TBS7, dal_tx, busy, done, nxm}, 0);
    chk("arst_tdal", TDAL, 0);
    repeat (2) @(negedge clk20);
    reset = 1'b0;
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk20);
      saw |= done;
    end
    chk("arst_no_done", saw, 0);
    chk("arst_rdata", rdata, 0);

    v = '{1'b0, 1'b0, 22'o17777546, 1'b1, 16'h0000, 16'o052525, 6, 1'b0, 1'b0, 16'o052525};
    run_txn(v);
    chk("sb_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
